// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and immediate extractors for the IF/ID redirect logic.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic {
      ST_RUN,
      ST_SQUASH
   } redirect_state_e;

   function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] insn);
      return {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] insn);
      return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] insn);
      return {{21{insn[31]}}, insn[30:20]};
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: funct3-selected compare of rs1 against rs2.
module branch_cmp
   import riscv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        funct3_i,
   input  logic [DATA_W-1:0] rs1_i,
   input  logic [DATA_W-1:0] rs2_i,
   output logic              taken_o
);

   logic eq;
   logic lt_s;
   logic lt_u;

   assign eq   = (rs1_i == rs2_i);
   assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
   assign lt_u = (rs1_i < rs2_i);

   // Reserved funct3 encodings (010, 011) fall through to not-taken.
   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = eq;
         F3_BNE:  taken_o = ~eq;
         F3_BLT:  taken_o = lt_s;
         F3_BGE:  taken_o = ~lt_s;
         F3_BLTU: taken_o = lt_u;
         F3_BGEU: taken_o = ~lt_u;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/if_id_redirect.sv
// IF/ID pipeline register with early BRANCH/JAL/JALR resolution, redirect to IF
// and a small squash FSM that discards wrong-path fetches after each redirect.
module if_id_redirect
   import riscv_pkg::*;
#(
   parameter int                ADDR_W    = 31,
   parameter int                DATA_W    = 32,
   parameter int                FETCH_LAT = 1,
   parameter logic [DATA_W-1:0] NOP       = NOP_INSN
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [DATA_W-1:0] i_instruccion,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_rs1_data,
   input  logic [DATA_W-1:0] i_rs2_data,
   output logic [ADDR_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_instruccion,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_branch_address,
   output logic              o_select,
   output logic [DATA_W-1:0] o_link_data,
   output logic              o_misaligned
);

   localparam int              CNT_W       = 2;
   localparam logic [CNT_W-1:0] SQUASH_INIT = CNT_W'(FETCH_LAT);

   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   redirect_state_e   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              is_branch;
   logic              is_jal;
   logic              is_jalr;
   logic              cmp_taken;
   logic              taken;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] pc_byte;
   logic [DATA_W-1:0] jalr_sum;
   logic [DATA_W-1:0] tgt;
   logic              select;

   // ---------------------------------------------------------------- decode
   assign opcode    = instr_q[6:0];
   assign funct3    = instr_q[14:12];
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);

   branch_cmp #(
      .DATA_W (DATA_W)
   ) u_branch_cmp (
      .funct3_i (funct3),
      .rs1_i    (i_rs1_data),
      .rs2_i    (i_rs2_data),
      .taken_o  (cmp_taken)
   );

   always_comb begin
      imm = DATA_W'(imm_b(XLEN'(instr_q)));
      if (is_jal) begin
         imm = DATA_W'(imm_j(XLEN'(instr_q)));
      end else if (is_jalr) begin
         imm = DATA_W'(imm_i(XLEN'(instr_q)));
      end
   end

   // ------------------------------------------------- target (byte domain)
   assign pc_byte  = DATA_W'({pc_q, 2'b00});
   assign jalr_sum = i_rs1_data + imm;

   always_comb begin
      tgt = pc_byte + imm;
      if (is_jalr) begin
         tgt = {jalr_sum[DATA_W-1:1], 1'b0};
      end
   end

   assign taken    = o_valid & (is_jal | is_jalr | (is_branch & cmp_taken));
   assign select   = taken & ~tgt[1] & ~i_stall & ~i_flush;

   assign o_pc             = pc_q;
   assign o_instruccion    = instr_q;
   assign o_valid          = valid_q;
   assign o_select         = select;
   assign o_misaligned     = taken & tgt[1];
   assign o_branch_address = ADDR_W'(tgt >> 2);
   assign o_link_data      = DATA_W'({pc_q + ADDR_W'(1), 2'b00});

   // ------------------------------------------- register + squash FSM next
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      if (i_flush) begin
         instr_d = NOP;
         valid_d = 1'b0;
         state_d = ST_RUN;
         cnt_d   = '0;
      end else if (!i_stall) begin
         if (select || (cnt_q != '0)) begin
            instr_d = NOP;
            valid_d = 1'b0;
         end else begin
            pc_d    = i_address;
            instr_d = i_instruccion;
            valid_d = 1'b1;
         end

         case (state_q)
            ST_RUN: begin
               // With zero fetch latency the redirect edge itself is the only bubble.
               if (select && (SQUASH_INIT != '0)) begin
                  state_d = ST_SQUASH;
                  cnt_d   = SQUASH_INIT;
               end
            end
            ST_SQUASH: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pc_q    <= '0;
         instr_q <= NOP;
         valid_q <= 1'b0;
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_if_id_redirect.sv
// Self-checking bench for if_id_redirect: decode/target vector table plus
// hand-written squash, stall, flush and reset sequences.
module tb_if_id_redirect;

   localparam int ADDR_W = 31;
   localparam int DATA_W = 32;
   localparam logic [31:0] NOP_I  = 32'h0000_0013;
   localparam logic [31:0] ADDI_I = 32'h0040_0113;
   localparam logic [31:0] BEQ_I  = 32'h0020_8463;

   logic              i_clock;
   logic              i_reset_n;
   logic [ADDR_W-1:0] i_address;
   logic [DATA_W-1:0] i_instruccion;
   logic              i_stall;
   logic              i_flush;
   logic [DATA_W-1:0] i_rs1_data;
   logic [DATA_W-1:0] i_rs2_data;
   logic [ADDR_W-1:0] o_pc;
   logic [DATA_W-1:0] o_instruccion;
   logic              o_valid;
   logic [ADDR_W-1:0] o_branch_address;
   logic              o_select;
   logic [DATA_W-1:0] o_link_data;
   logic              o_misaligned;

   int n_cmp  = 0;
   int n_fail = 0;

   if_id_redirect #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .FETCH_LAT (1)
   ) dut (
      .i_clock          (i_clock),
      .i_reset_n        (i_reset_n),
      .i_address        (i_address),
      .i_instruccion    (i_instruccion),
      .i_stall          (i_stall),
      .i_flush          (i_flush),
      .i_rs1_data       (i_rs1_data),
      .i_rs2_data       (i_rs2_data),
      .o_pc             (o_pc),
      .o_instruccion    (o_instruccion),
      .o_valid          (o_valid),
      .o_branch_address (o_branch_address),
      .o_select         (o_select),
      .o_link_data      (o_link_data),
      .o_misaligned     (o_misaligned)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   typedef struct {
      logic [30:0] pc;
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        sel;
      logic [30:0] baddr;
      logic        mis;
      logic [31:0] link;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];
   vec_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   initial begin
      vec_t e;

      //           pc            insn          rs1           rs2           sel   baddr         mis   link
      vecs[0]  = '{31'h400,      ADDI_I,       32'd0,        32'd0,        1'b0, 31'h0,        1'b0, 32'h1004};
      vecs[1]  = '{31'h402,      BEQ_I,        32'd5,        32'd5,        1'b1, 31'h404,      1'b0, 32'h100C};
      vecs[2]  = '{31'h402,      BEQ_I,        32'd5,        32'd6,        1'b0, 31'h0,        1'b0, 32'h100C};
      vecs[3]  = '{31'h402,      32'h0020_9463, 32'd5,       32'd6,        1'b1, 31'h404,      1'b0, 32'h100C};
      vecs[4]  = '{31'h402,      32'h0020_C463, 32'hFFFF_FFFF, 32'd1,      1'b1, 31'h404,      1'b0, 32'h100C};
      vecs[5]  = '{31'h402,      32'h0020_E463, 32'hFFFF_FFFF, 32'd1,      1'b0, 31'h0,        1'b0, 32'h100C};
      vecs[6]  = '{31'h402,      32'h0020_D463, 32'd1,       32'hFFFF_FFFF, 1'b1, 31'h404,      1'b0, 32'h100C};
      vecs[7]  = '{31'h402,      32'h0020_F463, 32'd1,       32'hFFFF_FFFF, 1'b0, 31'h0,        1'b0, 32'h100C};
      vecs[8]  = '{31'h402,      32'h0020_F463, 32'd7,       32'd7,        1'b1, 31'h404,      1'b0, 32'h100C};
      vecs[9]  = '{31'h402,      32'h0020_A463, 32'd7,       32'd7,        1'b0, 31'h0,        1'b0, 32'h100C};
      vecs[10] = '{31'h100,      32'h0100_00EF, 32'd0,       32'd0,        1'b1, 31'h104,      1'b0, 32'h0404};
      vecs[11] = '{31'h200,      32'hFFDF_F06F, 32'd0,       32'd0,        1'b1, 31'h1FF,      1'b0, 32'h0804};
      vecs[12] = '{31'h300,      32'h0000_0063, 32'd0,       32'd0,        1'b1, 31'h300,      1'b0, 32'h0C04};
      vecs[13] = '{31'h7FFF_FFFF, BEQ_I,       32'd3,       32'd3,        1'b1, 31'h1,        1'b0, 32'h0000};
      vecs[14] = '{31'h10,       32'h0000_8067, 32'h1002,    32'd0,        1'b0, 31'h0,        1'b1, 32'h0044};
      vecs[15] = '{31'h10,       32'h0000_8067, 32'h1010,    32'd0,        1'b1, 31'h404,      1'b0, 32'h0044};
      vecs[16] = '{31'h10,       32'h0000_8067, 32'h1011,    32'd0,        1'b1, 31'h404,      1'b0, 32'h0044};
      vecs[17] = '{31'h300,      32'h0000_0163, 32'd0,       32'd0,        1'b0, 31'h0,        1'b1, 32'h0C04};

      i_reset_n     = 1'b0;
      i_address     = '0;
      i_instruccion = '0;
      i_stall       = 1'b0;
      i_flush       = 1'b0;
      i_rs1_data    = '0;
      i_rs2_data    = '0;

      #12;
      check("reset.valid",  32'(o_valid),      32'd0);
      check("reset.select", 32'(o_select),     32'd0);
      check("reset.instr",  o_instruccion,     NOP_I);
      check("reset.pc",     32'(o_pc),         32'd0);
      check("reset.mis",    32'(o_misaligned), 32'd0);
      i_reset_n = 1'b1;

      // Table: capture one instruction, check combinational decode, flush back to a bubble.
      for (int k = 0; k < NV; k++) begin
         i_address     = vecs[k].pc;
         i_instruccion = vecs[k].insn;
         sb_q.push_back(vecs[k]);
         tick();
         i_rs1_data = vecs[k].rs1;
         i_rs2_data = vecs[k].rs2;
         #1;
         e = sb_q.pop_front();
         check($sformatf("v%0d.pc", k),    32'(o_pc),         32'(e.pc));
         check($sformatf("v%0d.instr", k), o_instruccion,     e.insn);
         check($sformatf("v%0d.valid", k), 32'(o_valid),      32'd1);
         check($sformatf("v%0d.sel", k),   32'(o_select),     32'(e.sel));
         check($sformatf("v%0d.mis", k),   32'(o_misaligned), 32'(e.mis));
         check($sformatf("v%0d.link", k),  o_link_data,       e.link);
         if (e.sel) check($sformatf("v%0d.baddr", k), 32'(o_branch_address), 32'(e.baddr));
         $display("vec %0d pc=%h insn=%h sel=%b baddr=%h mis=%b", k, o_pc, o_instruccion, o_select, o_branch_address, o_misaligned);
         i_flush = 1'b1;
         tick();
         i_flush = 1'b0;
      end

      // Taken BEQ then 1+FETCH_LAT bubbles, then the target fetch is captured.
      i_address = 31'h402; i_instruccion = BEQ_I; i_rs1_data = 32'd5; i_rs2_data = 32'd5;
      tick();
      check("sq.sel", 32'(o_select), 32'd1);
      check("sq.baddr", 32'(o_branch_address), 32'h404);
      i_address = 31'h403; i_instruccion = ADDI_I;
      tick();
      check("sq.bubble0", 32'(o_valid), 32'd0);
      check("sq.bubble0.instr", o_instruccion, NOP_I);
      i_address = 31'h7FF;
      tick();
      check("sq.bubble1", 32'(o_valid), 32'd0);
      i_address = 31'h404;
      tick();
      check("sq.capture.valid", 32'(o_valid), 32'd1);
      check("sq.capture.pc", 32'(o_pc), 32'h404);
      $display("seq squash done pc=%h valid=%b", o_pc, o_valid);

      // Stalled redirect is deferred; flush overrides it.
      i_address = 31'h402; i_instruccion = BEQ_I;
      tick();
      i_stall = 1'b1;
      #1;
      check("st.sel0", 32'(o_select), 32'd0);
      i_address = 31'h123; i_instruccion = ADDI_I;
      tick();
      check("st.hold.pc", 32'(o_pc), 32'h402);
      check("st.hold.instr", o_instruccion, BEQ_I);
      check("st.hold.sel", 32'(o_select), 32'd0);
      i_stall = 1'b0;
      #1;
      check("st.release.sel", 32'(o_select), 32'd1);
      i_flush = 1'b1;
      #1;
      check("fl.sel", 32'(o_select), 32'd0);
      tick();
      i_flush = 1'b0;
      check("fl.valid", 32'(o_valid), 32'd0);
      $display("seq stall/flush done pc=%h valid=%b", o_pc, o_valid);

      // Stall during SQUASH freezes the counter.
      i_address = 31'h402; i_instruccion = BEQ_I;
      tick();
      i_address = 31'h403; i_instruccion = ADDI_I;
      tick();
      i_stall = 1'b1;
      tick();
      tick();
      check("sst.stalled.valid", 32'(o_valid), 32'd0);
      i_stall = 1'b0;
      i_address = 31'h500;
      tick();
      check("sst.post.bubble", 32'(o_valid), 32'd0);
      tick();
      check("sst.capture.valid", 32'(o_valid), 32'd1);
      check("sst.capture.pc", 32'(o_pc), 32'h500);
      $display("seq stall-in-squash done pc=%h valid=%b", o_pc, o_valid);

      // Reset mid-SQUASH aborts the squash.
      i_address = 31'h402; i_instruccion = BEQ_I;
      tick();
      check("rs.sel", 32'(o_select), 32'd1);
      i_address = 31'h403; i_instruccion = ADDI_I;
      tick();
      #2;
      i_reset_n = 1'b0;
      #1;
      check("rs.valid", 32'(o_valid), 32'd0);
      check("rs.pc", 32'(o_pc), 32'd0);
      check("rs.instr", o_instruccion, NOP_I);
      check("rs.sel0", 32'(o_select), 32'd0);
      #2;
      i_reset_n = 1'b1;
      i_address = 31'h600;
      tick();
      check("rs.cap0.valid", 32'(o_valid), 32'd1);
      check("rs.cap0.pc", 32'(o_pc), 32'h600);
      i_address = 31'h601;
      tick();
      check("rs.cap1.valid", 32'(o_valid), 32'd1);
      check("rs.cap1.pc", 32'(o_pc), 32'h601);
      $display("seq reset-mid-squash done pc=%h valid=%b", o_pc, o_valid);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
